mem_write_sequencer: RTL
========================

Name: mem_write_sequencer

Overview:
Downstream neighbour of the memory input manager. Consumes its serialized 16-bit word stream and writes each word to consecutive memory addresses from a programmable base. A small FIFO decouples the stream from memory wait states. The block reports busy and done and signals completion with a done pulse.

Parameters:
DATA_W, 16, width of each data word and memory write port.
ADDR_W, 16, memory address width; address arithmetic is modulo 2^ADDR_W.
FIFO_DEPTH, 4, entries in the decoupling FIFO; power of two, at least 2.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
base_addr  input  ADDR_W  first write address, latched on start.
word_count  input  ADDR_W  number of words to write, latched on start; 0 is legal.
in_valid  input  1  upstream word valid.
in_data  input  DATA_W  upstream word.
in_ready  output  1  block accepts in_data this cycle.
mem_we  output  1  memory write request.
mem_addr  output  ADDR_W  write address.
mem_wdata  output  DATA_W  write data.
mem_ready  input  1  memory accepts the write this cycle (wait-state control).
busy  output  1  transfer in progress.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, FIFO empty, all counters=0. in_ready, mem_we, busy and done are 0. mem_addr and mem_wdata are 0. Reset takes effect immediately, including mid-transfer. Pending FIFO words are discarded.
- States: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=0; busy=0.
  - When start=1, latch base_addr into addr_ptr and word_count into target. Clear accepted and written.
  - Go to DONE if word_count==0, else to WRITE.
  - in_valid is ignored in IDLE.
- WRITE:
  - busy=1. start is ignored.
  - in_ready = !fifo_full && (accepted != target). in_ready is registered-state only, with no combinational path from mem_ready.
  - Push when in_valid && in_ready; accepted increments.
  - mem_we = !fifo_empty. mem_addr=addr_ptr. mem_wdata=FIFO head.
  - A write completes when mem_we && mem_ready. On completion: pop the FIFO, increment addr_ptr (wrapping 0xFFFF -> 0x0000 at default width), increment written.
  - mem_addr and mem_wdata stay stable while mem_we=1 && mem_ready=0.
  - When a completion makes written==target, go to DONE.
- DONE: busy=1, done=1 for exactly this cycle, then go to IDLE.
- Latency: a word accepted at cycle N is presented on mem_* at N+1 at the earliest. With mem_ready held high, throughput is 1 word/cycle.
- Full FIFO: in_ready=0 even if a pop occurs in the same cycle, so no push/pop bypass on full.
- Push and pop in the same cycle on a non-full, non-empty FIFO: both occur; occupancy is unchanged.
- Words offered after accepted==target are not accepted; in_ready stays 0 until the next transfer.
- No combinational path from in_valid or in_data to any mem_* output.

Decomposition:
- Shared package mem_pkg: DATA_W=16, ADDR_W=16, LANES=16 (the words-per-block constant already used by the input manager), the word and address typedefs, and the state enum {IDLE, WRITE, DONE}.
- One sub-module, sync_fifo, parameterized on width and depth:
  - ports clk, rst, push, pop, wdata, rdata, full, empty;
  - rdata is the head entry (show-ahead);
  - asynchronous active-high reset.

Test Plan:
1. Basic stream, mem_ready=1: base=0x0100, count=16, in_data 0x1111, 0x2222 … 0xFFFF, 0x0000 on consecutive cycles -> 16 writes to 0x0100..0x010F with matching data, one per cycle. done pulses once, one cycle after the last write; busy then falls.
2. Backpressure: same transfer with mem_ready low for 6 cycles after the first write -> FIFO fills to 4 and in_ready drops. mem_addr and mem_wdata stay stable during the stall. All 16 words are written in order, with no loss or duplication.
3. Wrap: base=0xFFFE, count=4, data 0xA001..0xA004 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001 with data in order.
4. Zero count: start with count=0 -> busy and done high the next cycle only. mem_we and in_ready never assert.
5. Reset mid-transfer: assert rst after 5 completed writes of a 16-word transfer -> mem_we, in_ready, busy and done go 0 immediately. A new start then writes from its new base with no stale data.
6. Illegal stimulus: start pulsed during WRITE and in_valid held in IDLE -> both ignored. The original transfer completes unchanged, and no words are accepted in IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the memory write path (input manager -> write sequencer).
package mem_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 16;
   // Words per block produced by the upstream input manager.
   localparam int unsigned LANES  = 16;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWrite = 2'd1,
      StDone  = 2'd2
   } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata_o always presents the head entry while not empty.
module sync_fifo
   import mem_pkg::*;
#(
   parameter int unsigned WIDTH = mem_pkg::DATA_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/mem_write_sequencer.sv
// Writes a stream of words to consecutive addresses from a latched base, decoupled by a FIFO.
module mem_write_sequencer
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W     = mem_pkg::DATA_W,
   parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W-1:0] word_count_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   output logic              busy_o,
   output logic              done_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic [ADDR_W-1:0] accepted_q, accepted_d;
   logic [ADDR_W-1:0] written_q, written_d;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              in_ready, mem_we;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (in_data_i),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // in_ready depends only on registered state, never on mem_ready_i.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      target_d   = target_q;
      accepted_d = accepted_q;
      written_d  = written_q;
      in_ready   = 1'b0;
      mem_we     = 1'b0;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               addr_d     = base_addr_i;
               target_d   = word_count_i;
               accepted_d = '0;
               written_d  = '0;
               state_d    = (word_count_i == '0) ? StDone : StWrite;
            end
         end
         StWrite: begin
            busy_o    = 1'b1;
            in_ready  = !fifo_full && (accepted_q != target_q);
            mem_we    = !fifo_empty;
            fifo_push = in_valid_i && in_ready;
            fifo_pop  = mem_we && mem_ready_i;
            if (fifo_push) begin
               accepted_d = accepted_q + ADDR_W'(1);
            end
            if (fifo_pop) begin
               addr_d    = addr_q + ADDR_W'(1);
               written_d = written_q + ADDR_W'(1);
               if (written_d == target_q) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         target_q   <= '0;
         accepted_q <= '0;
         written_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         target_q   <= target_d;
         accepted_q <= accepted_d;
         written_q  <= written_d;
      end
   end

   assign in_ready_o  = in_ready;
   assign mem_we_o    = mem_we;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = mem_we ? fifo_head : '0;

   // A stalled write must hold its address and data until accepted.
   stall_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (mem_we_o && !mem_ready_i) |=> ($stable(mem_addr_o) && $stable(mem_wdata_o)));

   no_push_when_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
      in_ready_o |-> !fifo_full);

endmodule
